// File: rtl/bwd_scaler_feeder.sv
// Frame-gated FIFO feeding the backward linear layer INPUT_SCALER.
// A frame is released only once all of its elements are stored, since the layer cannot stall.
module bwd_scaler_feeder #(
    parameter int NUM_UNKNOWNS = 2,
    parameter int NUM_NONLIN   = 1,
    parameter int BIT_WIDTH    = 32,
    parameter int EXTRA_BITS   = 2,
    parameter int DEPTH        = 8
) (
    input  logic                                CLK,
    input  logic                                RESET,
    input  logic                                WR_EN,
    input  logic [BIT_WIDTH+EXTRA_BITS-1:0]     WR_DATA,
    input  logic                                RD_READY,
    output logic [BIT_WIDTH+EXTRA_BITS-1:0]     SCALER,
    output logic                                SCALER_VALID,
    output logic                                FRAME_START,
    output logic                                FRAME_LAST,
    output logic                                FULL,
    output logic                                EMPTY,
    output logic [$clog2(DEPTH):0]              COUNT,
    output logic                                OVERFLOW
);

    localparam int FL = NUM_UNKNOWNS + NUM_NONLIN;
    localparam int W  = BIT_WIDTH + EXTRA_BITS;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = (FL > 1) ? $clog2(FL) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [IW-1:0] idx;
    logic [W-1:0]  scaler_q;
    logic          overflow_q;
    state_t        state;

    logic push;
    logic pop;
    logic frame_ready;
    logic at_last;

    // A new frame may begin only when a full frame is already buffered.
    always_comb begin
        push        = WR_EN & ~FULL;
        frame_ready = (count >= CW'(FL)) && RD_READY;
        at_last     = (idx == IW'(FL - 1));
        pop         = 1'b0;
        unique case (state)
            IDLE:   pop = frame_ready;
            STREAM: pop = ~at_last | frame_ready;
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            idx        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            scaler_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (WR_EN && FULL) begin
                overflow_q <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                scaler_q <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);

            // A started frame always runs to completion regardless of RD_READY.
            unique case (state)
                IDLE: begin
                    idx <= '0;
                    if (frame_ready) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (!at_last) begin
                        idx <= idx + IW'(1);
                    end else begin
                        idx <= '0;
                        if (!frame_ready) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    assign SCALER       = scaler_q;
    assign SCALER_VALID = (state == STREAM);
    assign FRAME_START  = SCALER_VALID & (idx == '0);
    assign FRAME_LAST   = SCALER_VALID & at_last;
    assign FULL         = (count == CW'(DEPTH));
    assign EMPTY        = (count == '0);
    assign COUNT        = count;
    assign OVERFLOW     = overflow_q;

endmodule

// File: tb/tb_bwd_scaler_feeder.sv
// Directed self-checking bench for bwd_scaler_feeder with default parameters (FL=3, DEPTH=8, W=34).
module tb_bwd_scaler_feeder;

    localparam int W = 34;

    logic         clk;
    logic         rst_n;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         rd_ready;
    logic [W-1:0] scaler;
    logic         scaler_valid;
    logic         frame_start;
    logic         frame_last;
    logic         full;
    logic         empty;
    logic [3:0]   count;
    logic         overflow;

    int tests_run = 0;
    int failures  = 0;

    localparam logic [W-1:0] F1 = 34'h0_3F80_0000;
    localparam logic [W-1:0] F2 = 34'h0_4000_0000;
    localparam logic [W-1:0] F3 = 34'h0_4040_0000;

    bwd_scaler_feeder dut (
        .CLK          (clk),
        .RESET        (rst_n),
        .WR_EN        (wr_en),
        .WR_DATA      (wr_data),
        .RD_READY     (rd_ready),
        .SCALER       (scaler),
        .SCALER_VALID (scaler_valid),
        .FRAME_START  (frame_start),
        .FRAME_LAST   (frame_last),
        .FULL         (full),
        .EMPTY        (empty),
        .COUNT        (count),
        .OVERFLOW     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        wr_en    = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        #2 rst_n = 1'b0;
        #7 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        apply_reset();
        tests_run++;
        if ({scaler, scaler_valid, frame_start, frame_last, full, empty, count, overflow}
            !== {34'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_values: scaler=%h v=%b s=%b l=%b full=%b empty=%b count=%0d ovf=%b, required all zero with empty=1",
                     scaler, scaler_valid, frame_start, frame_last, full, empty, count, overflow);
        end
    endtask

    task automatic test_basic_frame;
        logic [W-1:0] vals [3];
        vals[0] = F1; vals[1] = F2; vals[2] = F3;
        apply_reset();
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = vals[i];
            tick();
        end
        wr_en = 1'b0;
        tests_run++;
        if (scaler_valid !== 1'b0 || count !== 4'd3) begin
            failures++;
            $display("[TB] FAIL basic_fill: valid=%b count=%0d, required valid=0 count=3", scaler_valid, count);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (scaler_valid !== 1'b1 || scaler !== vals[i] ||
                frame_start !== (i == 0) || frame_last !== (i == 2)) begin
                failures++;
                $display("[TB] FAIL basic_elem%0d: v=%b data=%h s=%b l=%b, required v=1 data=%h s=%b l=%b",
                         i, scaler_valid, scaler, frame_start, frame_last, vals[i], i == 0, i == 2);
            end
        end
        tick();
        tests_run++;
        if (scaler_valid !== 1'b0 || empty !== 1'b1 || scaler !== F3) begin
            failures++;
            $display("[TB] FAIL basic_after: v=%b empty=%b data=%h, required v=0 empty=1 data=%h",
                     scaler_valid, empty, scaler, F3);
        end
    endtask

    task automatic test_partial_frame;
        logic seen_valid;
        apply_reset();
        rd_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wr_en = 1'b1; wr_data = 34'h1_0000_0010 + 34'(i);
            tick();
        end
        wr_en = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (scaler_valid) seen_valid = 1'b1;
        end
        tests_run++;
        if (seen_valid !== 1'b0 || count !== 4'd2) begin
            failures++;
            $display("[TB] FAIL partial_hold: valid_seen=%b count=%0d, required 0 and 2", seen_valid, count);
        end
        wr_en = 1'b1; wr_data = 34'h1_0000_0012;
        tick();
        wr_en = 1'b0;
        tick();
        tests_run++;
        if (scaler_valid !== 1'b1 || frame_start !== 1'b1 || scaler !== 34'h1_0000_0010) begin
            failures++;
            $display("[TB] FAIL partial_start: v=%b s=%b data=%h, required v=1 s=1 data=100000010",
                     scaler_valid, frame_start, scaler);
        end
        tick();
        tick();
        tests_run++;
        if (frame_last !== 1'b1 || scaler !== 34'h1_0000_0012) begin
            failures++;
            $display("[TB] FAIL partial_last: l=%b data=%h, required l=1 data=100000012", frame_last, scaler);
        end
        tick();
    endtask

    task automatic test_two_frames;
        apply_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 34'h0_0000_0A00 + 34'(i);
            tick();
        end
        wr_en = 1'b0;
        tick();
        tick();
        tests_run++;
        if (scaler_valid !== 1'b0 || count !== 4'd6) begin
            failures++;
            $display("[TB] FAIL held_not_ready: v=%b count=%0d, required v=0 count=6", scaler_valid, count);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if (scaler_valid !== 1'b1 || scaler !== 34'h0_0000_0A00 + 34'(i) ||
                frame_start !== (i == 0 || i == 3) || frame_last !== (i == 2 || i == 5)) begin
                failures++;
                $display("[TB] FAIL two_frames_c%0d: v=%b data=%h s=%b l=%b, required v=1 data=%h s=%b l=%b",
                         i + 1, scaler_valid, scaler, frame_start, frame_last,
                         34'h0_0000_0A00 + 34'(i), i == 0 || i == 3, i == 2 || i == 5);
            end
        end
        tick();
        tests_run++;
        if (scaler_valid !== 1'b0 || empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL two_frames_end: v=%b empty=%b, required v=0 empty=1", scaler_valid, empty);
        end
    endtask

    task automatic test_overflow;
        logic [W-1:0] exp_out [9];
        apply_reset();
        rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 34'h2_0000_0B00 + 34'(i);
            exp_out[i] = 34'h2_0000_0B00 + 34'(i);
            tick();
        end
        tests_run++;
        if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b0) begin
            failures++;
            $display("[TB] FAIL fill_depth: full=%b count=%0d ovf=%b, required 1 8 0", full, count, overflow);
        end
        wr_data = 34'h3_DEAD_BEEF;
        tick();
        wr_en = 1'b0;
        tests_run++;
        if (full !== 1'b1 || count !== 4'd8 || overflow !== 1'b1) begin
            failures++;
            $display("[TB] FAIL overflow_set: full=%b count=%0d ovf=%b, required 1 8 1", full, count, overflow);
        end
        rd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if (scaler_valid !== 1'b1 || scaler !== exp_out[i]) begin
                failures++;
                $display("[TB] FAIL ovf_drain%0d: v=%b data=%h, required v=1 data=%h",
                         i, scaler_valid, scaler, exp_out[i]);
            end
        end
        tick();
        tests_run++;
        if (scaler_valid !== 1'b0 || count !== 4'd2) begin
            failures++;
            $display("[TB] FAIL ovf_remainder: v=%b count=%0d, required v=0 count=2", scaler_valid, count);
        end
        wr_en = 1'b1; wr_data = 34'h2_0000_0C00;
        exp_out[8] = 34'h2_0000_0C00;
        tick();
        wr_en = 1'b0;
        for (int i = 6; i < 9; i++) begin
            int j;
            j = (i == 8) ? 8 : i;
            tick();
            tests_run++;
            if (scaler_valid !== 1'b1 || scaler !== exp_out[j]) begin
                failures++;
                $display("[TB] FAIL ovf_tail%0d: v=%b data=%h, required v=1 data=%h",
                         i, scaler_valid, scaler, exp_out[j]);
            end
        end
        tick();
        tests_run++;
        if (overflow !== 1'b1 || empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_sticky: ovf=%b empty=%b, required ovf=1 empty=1", overflow, empty);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] exp_q [$];
        logic [W-1:0] exp_v;
        int n_valid;
        int first_valid;
        int last_valid;
        int pos;
        apply_reset();
        rd_ready    = 1'b1;
        n_valid     = 0;
        first_valid = -1;
        last_valid  = -1;
        for (int i = 0; i < 22; i++) begin
            if (i < 15) begin
                wr_en = 1'b1; wr_data = 34'h1_5000_0000 + 34'(i * 7);
                exp_q.push_back(34'h1_5000_0000 + 34'(i * 7));
            end else begin
                wr_en = 1'b0;
            end
            tick();
            if (i == 9) begin
                tests_run++;
                if (count !== 4'd3) begin
                    failures++;
                    $display("[TB] FAIL b2b_count: count=%0d, required 3", count);
                end
            end
            if (scaler_valid) begin
                pos = n_valid % 3;
                if (first_valid < 0) first_valid = i;
                last_valid = i;
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                tests_run++;
                if (scaler !== exp_v || frame_start !== (pos == 0) || frame_last !== (pos == 2)) begin
                    failures++;
                    $display("[TB] FAIL b2b_elem%0d: data=%h s=%b l=%b, required data=%h s=%b l=%b",
                             n_valid, scaler, frame_start, frame_last, exp_v, pos == 0, pos == 2);
                end
                n_valid++;
            end
        end
        wr_en = 1'b0;
        tests_run++;
        if (n_valid != 15 || first_valid != 3 || last_valid != 17 || empty !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_span: valid=%0d first=%0d last=%0d empty=%b, required 15 3 17 1",
                     n_valid, first_valid, last_valid, empty);
        end
    endtask

    task automatic test_reset_mid_frame;
        apply_reset();
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 34'h0_7700_0000 + 34'(i);
            tick();
        end
        wr_en = 1'b1; wr_data = 34'h0_7700_0003;
        tick();
        wr_en = 1'b0;
        tick();
        tests_run++;
        if (scaler_valid !== 1'b1 || scaler !== 34'h0_7700_0001) begin
            failures++;
            $display("[TB] FAIL mid_second_elem: v=%b data=%h, required v=1 data=077000001", scaler_valid, scaler);
        end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({scaler, scaler_valid, frame_start, frame_last, full, empty, count, overflow}
            !== {34'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL async_reset: scaler=%h v=%b s=%b l=%b full=%b empty=%b count=%0d ovf=%b, required reset values",
                     scaler, scaler_valid, frame_start, frame_last, full, empty, count, overflow);
        end
        #3 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            wr_en = 1'b1; wr_data = 34'h0_8800_0000 + 34'(i);
            tick();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        tests_run++;
        if (scaler_valid !== 1'b0 || count !== 4'd2) begin
            failures++;
            $display("[TB] FAIL post_reset_hold: v=%b count=%0d, required v=0 count=2", scaler_valid, count);
        end
        wr_en = 1'b1; wr_data = 34'h0_8800_0002;
        tick();
        wr_en = 1'b0;
        tick();
        tests_run++;
        if (scaler_valid !== 1'b1 || frame_start !== 1'b1 || scaler !== 34'h0_8800_0000) begin
            failures++;
            $display("[TB] FAIL post_reset_frame: v=%b s=%b data=%h, required v=1 s=1 data=088000000",
                     scaler_valid, frame_start, scaler);
        end
        tick();
        tick();
        tick();
    endtask

    initial begin
        rst_n    = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        test_reset();
        test_basic_frame();
        test_partial_frame();
        test_two_frames();
        test_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
